// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array front end: feeder states,
// array geometry and the byte-lane convention of the packed buffer words.
package tpu_pkg;

  localparam int ARRAY_ROWS = 4;
  localparam int ARRAY_COLS = 4;
  localparam int DATA_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

  // Buffer words carry lane 0 in the most significant byte.
  function automatic int lane_msb(int lane, int n_lanes, int w);
    return n_lanes * w - 1 - lane * w;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register used to stagger one operand lane by DEPTH cycles.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/operand_feeder.sv
// Reads A/B operand words, skews each lane by its index and sequences the
// clear/enable controls of the systolic PE array.
module operand_feeder #(
  parameter int N_ROWS = tpu_pkg::ARRAY_ROWS,
  parameter int N_COLS = tpu_pkg::ARRAY_COLS,
  parameter int DATA_W = tpu_pkg::DATA_W,
  parameter int ADDR_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               k_len,
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        A_index,
  input  logic [N_ROWS*DATA_W-1:0] A_data_out,
  output logic [ADDR_W-1:0]        B_index,
  input  logic [N_COLS*DATA_W-1:0] B_data_out,
  output logic [N_ROWS*DATA_W-1:0] left_data,
  output logic [N_COLS*DATA_W-1:0] top_data,
  output logic                     pe_clear,
  output logic                     pe_enable
);
  import tpu_pkg::*;

  // Last DRAIN count: the deepest lane needs D+1 zero pushes to flush.
  localparam logic [7:0] DRAIN_LAST = 8'(N_ROWS + N_COLS - 1);

  feeder_state_t state, state_nxt;
  logic [7:0]    k_q, cnt, last_idx, idx;
  logic          fetch;

  assign last_idx = (k_q == 8'd0) ? 8'd0 : k_q - 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k_q   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) k_q <= k_len;
      cnt <= (state_nxt != state || state == ST_IDLE) ? 8'd0 : cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = (k_q == 8'd0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (cnt == last_idx) state_nxt = ST_DRAIN;
      ST_DRAIN: if (cnt == DRAIN_LAST) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    pe_clear  = (state == ST_CLEAR);
    fetch     = (state == ST_FETCH);
    // Word 0 reaches the lane heads one cycle into FETCH, so the array steps from then on.
    pe_enable = (fetch && cnt != 8'd0) || (state == ST_DRAIN);
    idx       = 8'd0;
    case (state)
      ST_FETCH:         idx = (cnt == last_idx) ? cnt : cnt + 8'd1;
      ST_DRAIN, ST_DONE: idx = last_idx;
      default:          idx = 8'd0;
    endcase
  end

  assign A_index = ADDR_W'(idx);
  assign B_index = ADDR_W'(idx);

  for (genvar i = 0; i < N_ROWS; i++) begin : g_row
    logic [DATA_W-1:0] head;
    assign head = fetch ? A_data_out[lane_msb(i, N_ROWS, DATA_W) -: DATA_W] : '0;
    skew_delay_line #(.DEPTH(i + 1), .WIDTH(DATA_W)) u_dl (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (head),
      .q     (left_data[i*DATA_W +: DATA_W])
    );
  end

  for (genvar j = 0; j < N_COLS; j++) begin : g_col
    logic [DATA_W-1:0] head;
    assign head = fetch ? B_data_out[lane_msb(j, N_COLS, DATA_W) -: DATA_W] : '0;
    skew_delay_line #(.DEPTH(j + 1), .WIDTH(DATA_W)) u_dl (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (head),
      .q     (top_data[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed bench for operand_feeder: per-cycle trace capture of each job,
// compared against hand-derived skew, index and control timing.
module tb_operand_feeder;

  localparam int D = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  k_len = 8'd0;
  logic        busy, done, pe_clear, pe_enable;
  logic [15:0] a_index, b_index;
  logic [31:0] a_data = '0, b_data = '0;
  logic [31:0] left_data, top_data;

  always #5 clk = ~clk;

  operand_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .A_index    (a_index),
    .A_data_out (a_data),
    .B_index    (b_index),
    .B_data_out (b_data),
    .left_data  (left_data),
    .top_data   (top_data),
    .pe_clear   (pe_clear),
    .pe_enable  (pe_enable)
  );

  // Global buffer model: one-cycle read latency.
  logic [31:0] amem [256];
  logic [31:0] bmem [256];
  always @(posedge clk) begin
    a_data <= amem[a_index[7:0]];
    b_data <= bmem[b_index[7:0]];
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          ncyc;
  int          max_idx;
  logic [31:0] r_left [300];
  logic [31:0] r_top  [300];
  logic [15:0] r_aidx [300];
  logic [15:0] r_bidx [300];
  logic        r_clr  [300];
  logic        r_en   [300];
  logic        r_done [300];
  logic        r_busy [300];

  function automatic int done_cycle(input int k);
    return (k == 0) ? 2 : k + D + 3;
  endfunction

  // Issue one job; optionally re-pulse start (with a different k_len) at
  // cycle pulse_c and in the DONE cycle. Records c1..done+extra.
  task automatic run_job(input int k, input int extra, input int pulse_c);
    int dc;
    dc = done_cycle(k);
    @(negedge clk);
    start = 1'b1;
    k_len = k[7:0];
    ncyc  = dc + extra;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      r_left[c] = left_data;  r_top[c]  = top_data;
      r_aidx[c] = a_index;    r_bidx[c] = b_index;
      r_clr[c]  = pe_clear;   r_en[c]   = pe_enable;
      r_done[c] = done;       r_busy[c] = busy;
      if (pulse_c > 0 && (c == pulse_c || c == dc)) begin
        start = 1'b1;
        k_len = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_job(input int k, input string tag);
    int dc, n_clr, n_en, first_en, last_en, n_done, done_at, n_busy;
    int bad_l, bad_t, bad_i, ei, jw;
    logic [31:0] w;
    logic [7:0]  ea, eb;
    dc = done_cycle(k);
    n_clr = 0; n_en = 0; first_en = 0; last_en = 0; n_done = 0; done_at = 0;
    n_busy = 0; bad_l = 0; bad_t = 0; bad_i = 0; max_idx = 0;
    for (int c = 1; c <= ncyc; c++) begin
      n_clr  += int'(r_clr[c]);
      n_busy += int'(r_busy[c]);
      if (r_en[c]) begin
        n_en++;
        if (first_en == 0) first_en = c;
        last_en = c;
      end
      if (r_done[c]) begin
        n_done++;
        done_at = c;
      end
      ei = 0;
      if (k > 0 && c >= 2 && c <= dc) ei = (c <= k + 1 && c - 1 < k - 1) ? c - 1 : k - 1;
      if (r_aidx[c] != 16'(ei) || r_bidx[c] != 16'(ei)) bad_i++;
      if (int'(r_aidx[c]) > max_idx) max_idx = int'(r_aidx[c]);
      for (int i = 0; i < 4; i++) begin
        jw = c - 3 - i;
        ea = 8'h00; eb = 8'h00;
        if (jw >= 0 && jw < k) begin
          w  = amem[jw];  ea = w[31-8*i -: 8];
          w  = bmem[jw];  eb = w[31-8*i -: 8];
        end
        if (r_left[c][8*i +: 8] !== ea) bad_l++;
        if (r_top[c][8*i +: 8]  !== eb) bad_t++;
      end
    end
    chk({tag, "_clear_cnt"}, n_clr, 1);
    chk({tag, "_clear_c1"}, r_clr[1], 1'b1);
    chk({tag, "_en_cnt"}, n_en, (k == 0) ? 0 : k + D);
    chk({tag, "_en_first"}, first_en, (k == 0) ? 0 : 3);
    chk({tag, "_en_last"}, last_en, (k == 0) ? 0 : k + D + 2);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_done_at"}, done_at, dc);
    chk({tag, "_busy_cnt"}, n_busy, dc);
    chk({tag, "_left_trace"}, bad_l, 0);
    chk({tag, "_top_trace"}, bad_t, 0);
    chk({tag, "_index_trace"}, bad_i, 0);
  endtask

  function automatic logic [127:0] all_outs();
    return {28'd0, busy, done, pe_clear, pe_enable, a_index, b_index, left_data, top_data};
  endfunction

  initial begin
    int seen;
    for (int w = 0; w < 256; w++) begin
      for (int b = 0; b < 4; b++) begin
        amem[w][31-8*b -: 8] = 8'(4 * w + b + 1);
        bmem[w][31-8*b -: 8] = 8'(4 * w + b + 1 + 16);
      end
    end

    #2;
    chk("reset_outputs", all_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // Reference job, k=4.
    run_job(4, 2, 0);
    check_job(4, "k4");
    chk("k4_left0_c3", r_left[3][7:0], 8'h01);
    chk("k4_left3_c6", r_left[6][31:24], 8'h04);
    chk("k4_left3_c9", r_left[9][31:24], 8'h10);
    chk("k4_top2_c5", r_top[5][23:16], 8'h13);
    chk("k4_idx_c1_c5", {r_aidx[1], r_aidx[2], r_aidx[3], r_aidx[4], r_aidx[5]},
        {16'd0, 16'd1, 16'd2, 16'd3, 16'd3});
    chk("k4_busy_after", r_busy[15], 1'b0);

    // Empty job.
    run_job(0, 1, 0);
    check_job(0, "k0");

    // Start re-pulsed mid-job and in DONE, with k_len changed; both ignored.
    run_job(4, 2, 5);
    check_job(4, "k4_pulse");
    chk("k4_pulse_no_restart", {r_busy[15], r_busy[16]}, 2'b00);

    // Back-to-back: second start lands in the IDLE cycle right after DONE.
    run_job(2, 0, 0);
    check_job(2, "b2b_a");
    run_job(3, 1, 0);
    check_job(3, "b2b_b");

    // Asynchronous reset during FETCH cycle 2 of a k=8 job.
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd8;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rst_pre_busy", busy, 1'b1);
    chk("rst_pre_left0", left_data[7:0], 8'h05);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", all_outs(), '0);
    @(negedge clk);
    chk("rst_held_outputs", all_outs(), '0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      seen += int'(done) + int'(busy);
    end
    chk("rst_no_done", seen, 0);
    run_job(1, 1, 0);
    check_job(1, "after_rst");

    // Longest job: index saturates at 254.
    run_job(255, 1, 0);
    check_job(255, "k255");
    chk("k255_max_idx", max_idx, 254);
    chk("k255_idx_done", r_aidx[265], 16'd254);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
